// File: rtl/router_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// router_ingress_ctrl
//
// Ingress controller for the 1x3 router. A byte-serial packet arrives as
//   header (dest in [1:0], payload length L in [7:2]), L payload bytes and
//   one parity byte (XOR of header and all payload bytes).
// The controller steers each accepted byte to one of three output FIFOs,
// marks the header write, applies backpressure when the target FIFO is full,
// flags bad packets (bad parity or invalid destination), and issues a
// per-FIFO soft reset when a downstream reader leaves a non-empty FIFO
// unread for TIMEOUT consecutive cycles.
//
// Parameters
//   TIMEOUT  cycles a non-empty FIFO may sit unread before soft_reset pulses
//   TW       timeout counter width; 2**TW must exceed TIMEOUT
//
// Ports
//   clock         in   system clock, all state on posedge
//   resetn        in   synchronous, active-low reset
//   pkt_valid     in   source byte valid
//   data_in       in   [7:0] source byte
//   fifo_full     in   [2:0] full flag of FIFO 0..2
//   fifo_empty    in   [2:0] empty flag of FIFO 0..2
//   read_enb      in   [2:0] downstream read strobe per FIFO
//   busy          out  backpressure; a byte transfers only on pkt_valid && !busy
//   write_enb     out  [2:0] one-hot FIFO write strobe (combinational)
//   data_to_fifo  out  [7:0] byte to FIFOs, equal to data_in
//   lfd_state     out  high with the header write
//   vld_out       out  [2:0] ~fifo_empty
//   soft_reset    out  [2:0] registered one-cycle clear pulse per FIFO
//   err           out  registered one-cycle bad-packet pulse
// -----------------------------------------------------------------------------
module router_ingress_ctrl #(
  parameter int TIMEOUT = 30,
  parameter int TW      = 5
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [7:0] data_in,
  input  logic [2:0] fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] read_enb,
  output logic       busy,
  output logic [2:0] write_enb,
  output logic [7:0] data_to_fifo,
  output logic       lfd_state,
  output logic [2:0] vld_out,
  output logic [2:0] soft_reset,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DROP
  } state_t;

  localparam logic [1:0]    DEST_INVALID = 2'd3;
  localparam logic [TW-1:0] TCNT_LAST    = TW'(TIMEOUT - 1);

  // Select one bit of a 3-bit per-FIFO vector; destination 3 maps to 0 so an
  // invalid header never looks at a non-existent FIFO.
  function automatic logic bit_at(input logic [2:0] vec, input logic [1:0] idx);
    case (idx)
      2'd0:    return vec[0];
      2'd1:    return vec[1];
      2'd2:    return vec[2];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t        r_state;
  logic [1:0]    r_dest;
  logic [6:0]    r_rem;        // bytes still to come, including parity
  logic [7:0]    r_par;        // running XOR of header and payload
  logic [TW-1:0] r_tcnt [3];   // per-FIFO unread-cycle counters
  logic [2:0]    r_soft_reset;
  logic          r_err;

  // ---------------------------------------------------------------------------
  // Header decode and datapath
  // ---------------------------------------------------------------------------
  logic [1:0] w_dest_in;
  logic [5:0] w_len_in;
  logic       w_hdr_valid;
  logic       w_in_packet;
  logic       w_sr_hit;
  logic       w_drop_mode;
  logic       w_busy;
  logic       w_accept;
  logic [2:0] w_write_enb;
  logic       w_lfd;

  assign w_dest_in   = data_in[1:0];
  assign w_len_in    = data_in[7:2];
  assign w_hdr_valid = (w_dest_in != DEST_INVALID);

  // A soft reset of the FIFO the current packet is going to kills the rest of
  // that packet: from this cycle on it is consumed exactly like a drop.
  assign w_in_packet = (r_state == ST_PAYLOAD) || (r_state == ST_PARITY);
  assign w_sr_hit    = w_in_packet && bit_at(r_soft_reset, r_dest);
  assign w_drop_mode = (r_state == ST_DROP) || w_sr_hit;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_busy = 1'b0;
    unique case (r_state)
      ST_IDLE:               w_busy = pkt_valid && w_hdr_valid && bit_at(fifo_full, w_dest_in);
      ST_PAYLOAD, ST_PARITY: w_busy = !w_sr_hit && bit_at(fifo_full, r_dest);
      ST_DROP:               w_busy = 1'b0;
    endcase
  end

  assign w_accept = pkt_valid && !w_busy;

  always_comb begin
    w_write_enb = 3'b000;
    w_lfd       = 1'b0;
    if (w_accept) begin
      if (r_state == ST_IDLE) begin
        if (w_hdr_valid) begin
          w_write_enb = onehot3(w_dest_in);
          w_lfd       = 1'b1;
        end
      end else if (w_in_packet && !w_sr_hit) begin
        w_write_enb = onehot3(r_dest);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_dest  <= 2'd0;
      r_rem   <= 7'd0;
      r_par   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_drop_mode) begin
        // Drop path: consume bytes without writing; the last one flags err.
        if (w_accept) begin
          r_rem <= r_rem - 7'd1;
          if (r_rem == 7'd1) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b1;
          end else begin
            r_state <= ST_DROP;
          end
        end else begin
          r_state <= ST_DROP;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              r_rem <= {1'b0, w_len_in} + 7'd1;
              if (w_hdr_valid) begin
                r_dest  <= w_dest_in;
                r_par   <= data_in;
                r_state <= (w_len_in != 6'd0) ? ST_PAYLOAD : ST_PARITY;
              end else begin
                r_state <= ST_DROP;
              end
            end
          end
          ST_PAYLOAD: begin
            if (w_accept) begin
              r_par <= r_par ^ data_in;
              r_rem <= r_rem - 7'd1;
              // rem is about to become 1: only the parity byte remains.
              if (r_rem == 7'd2) r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
            if (w_accept) begin
              r_rem   <= r_rem - 7'd1;
              r_state <= ST_IDLE;
              r_err   <= |(r_par ^ data_in);
            end
          end
          ST_DROP: begin
            // Covered by the drop path above; listed to keep the case complete.
            r_state <= ST_DROP;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-FIFO read timeout
  // ---------------------------------------------------------------------------
  // The counter runs while the FIFO holds data nobody reads. On the cycle it
  // sits at TIMEOUT-1 and would advance again it wraps to zero and fires a
  // one-cycle soft_reset, so the pulse lands on the TIMEOUT+1-th cycle of an
  // unread non-empty FIFO.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // reset element by element like any other state.
      for (int i = 0; i < 3; i++) r_tcnt[i] <= '0;
      r_soft_reset <= 3'b000;
    end else begin
      r_soft_reset <= 3'b000;
      for (int i = 0; i < 3; i++) begin
        if (fifo_empty[i] || read_enb[i]) begin
          r_tcnt[i] <= '0;
        end else if (r_tcnt[i] == TCNT_LAST) begin
          r_tcnt[i]       <= '0;
          r_soft_reset[i] <= 1'b1;
        end else begin
          r_tcnt[i] <= r_tcnt[i] + TW'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy         = w_busy;
  assign write_enb    = w_write_enb;
  assign lfd_state    = w_lfd;
  assign data_to_fifo = data_in;
  assign vld_out      = ~fifo_empty;
  assign soft_reset   = r_soft_reset;
  assign err          = r_err;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
  a_write_onehot : assert property (@(posedge clock) disable iff (!resetn)
    $onehot0(write_enb));
  a_lfd_in_idle : assert property (@(posedge clock) disable iff (!resetn)
    lfd_state |-> (r_state == ST_IDLE) && (write_enb != 3'b000));

endmodule

// File: tb/tb_router_ingress_ctrl.sv
// -----------------------------------------------------------------------------
// tb_router_ingress_ctrl
//
// Directed bench for router_ingress_ctrl. Inputs change on the falling edge;
// combinational outputs are sampled 1 time unit later, registered outputs
// (err, soft_reset) on the falling edge after the rising edge that loads them.
// -----------------------------------------------------------------------------
module tb_router_ingress_ctrl;

  logic       clock;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic [2:0] fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] read_enb;
  logic       busy;
  logic [2:0] write_enb;
  logic [7:0] data_to_fifo;
  logic       lfd_state;
  logic [2:0] vld_out;
  logic [2:0] soft_reset;
  logic       err;

  int n_total = 0;
  int n_pass  = 0;

  router_ingress_ctrl #(.TIMEOUT(30), .TW(5)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .read_enb     (read_enb),
    .busy         (busy),
    .write_enb    (write_enb),
    .data_to_fifo (data_to_fifo),
    .lfd_state    (lfd_state),
    .vld_out      (vld_out),
    .soft_reset   (soft_reset),
    .err          (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // One clock cycle of stimulus: drive after the falling edge, settle, return.
  task automatic cyc(input logic v, input logic [7:0] d,
                     input logic [2:0] full = 3'b000,
                     input logic [2:0] empty = 3'b111,
                     input logic [2:0] rd = 3'b000);
    @(negedge clock);
    pkt_valid  = v;
    data_in    = d;
    fifo_full  = full;
    fifo_empty = empty;
    read_enb   = rd;
    #1;
  endtask

  logic [7:0] pkt [5];
  int         k;
  logic       found;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
    repeat (2) @(negedge clock);
    #1;
    check("rst_err", err, 1'b0);
    check("rst_soft_reset", soft_reset, 3'b000);
    check("rst_write_enb", write_enb, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_lfd", lfd_state, 1'b0);
    check("rst_vld_out", vld_out, 3'b000);
    @(negedge clock);
    resetn = 1'b1;

    // Good packet: dest 1, L=3; 0x0D^0x11^0x22^0x33 = 0x0D.
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, pkt[i]);
      check("good_we", write_enb, 3'b010);
      check("good_lfd", lfd_state, (i == 0));
      check("good_busy", busy, 1'b0);
      check("good_data", data_to_fifo, pkt[i]);
      check("good_err_mid", err, 1'b0);
    end
    cyc(1'b0, 8'h00);
    check("good_err_after", err, 1'b0);
    check("good_idle_we", write_enb, 3'b000);

    // Same packet with wrong parity: all five bytes written, err one cycle.
    pkt[4] = 8'h0C;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, pkt[i]);
      check("bad_we", write_enb, 3'b010);
      check("bad_lfd", lfd_state, (i == 0));
    end
    cyc(1'b0, 8'h00);
    check("bad_err_pulse", err, 1'b1);
    cyc(1'b0, 8'h00);
    check("bad_err_clear", err, 1'b0);

    // Invalid destination 3, L=2: four bytes dropped, all FIFOs full.
    pkt = '{8'h0B, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, pkt[i], 3'b111);
      check("drop_we", write_enb, 3'b000);
      check("drop_busy", busy, 1'b0);
      check("drop_lfd", lfd_state, 1'b0);
      check("drop_err_mid", err, 1'b0);
    end
    cyc(1'b0, 8'h00);
    check("drop_err_pulse", err, 1'b1);
    cyc(1'b0, 8'h00);
    check("drop_err_clear", err, 1'b0);

    // Header to dest 2 (L=0) held off by fifo_full[2] for four cycles.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 8'h02, 3'b100);
      check("full_busy", busy, 1'b1);
      check("full_we", write_enb, 3'b000);
    end
    cyc(1'b1, 8'h02);
    check("full_hdr_we", write_enb, 3'b100);
    check("full_hdr_lfd", lfd_state, 1'b1);
    cyc(1'b1, 8'h02);
    check("full_par_we", write_enb, 3'b100);
    check("full_par_lfd", lfd_state, 1'b0);
    cyc(1'b0, 8'h00);
    check("full_err", err, 1'b0);

    // Timeout: FIFO 0 non-empty and unread; pulse on its 31st such cycle.
    for (k = 1; k <= 32; k++) begin
      cyc(1'b0, 8'h00, 3'b000, 3'b110);
      if (k == 1) check("to_vld_out", vld_out, 3'b001);
      check($sformatf("to_sr_c%0d", k), soft_reset, (k == 31) ? 3'b001 : 3'b000);
    end
    cyc(1'b0, 8'h00);

    // A read in cycle 20 restarts the count: pulse moves to cycle 51.
    for (k = 1; k <= 52; k++) begin
      cyc(1'b0, 8'h00, 3'b000, 3'b110, (k == 20) ? 3'b001 : 3'b000);
      check($sformatf("tor_sr_c%0d", k), soft_reset, (k == 51) ? 3'b001 : 3'b000);
    end
    cyc(1'b0, 8'h00);

    // Soft reset of FIFO 1 mid-packet: header 0x15 (dest 1, L=5) + 3 payload,
    // leaving 2 payload + parity. FIFO 1 then sits full and unread.
    cyc(1'b1, 8'h15);
    check("sr_hdr_we", write_enb, 3'b010);
    cyc(1'b1, 8'h01);
    cyc(1'b1, 8'h02);
    cyc(1'b1, 8'h03);
    check("sr_pay_we", write_enb, 3'b010);
    found = 1'b0;
    for (k = 1; k <= 40 && !found; k++) begin
      @(negedge clock);
      fifo_full  = 3'b010;
      fifo_empty = 3'b101;
      read_enb   = 3'b000;
      if (soft_reset[1]) begin
        found     = 1'b1;
        pkt_valid = 1'b1;
        data_in   = 8'h04;
      end else begin
        pkt_valid = 1'b0;
        data_in   = 8'h00;
      end
      #1;
      if (k == 1) check("sr_wait_busy", busy, 1'b1);
      if (found) check("sr_cycle", k, 31);
    end
    if (!found) check("sr_seen", found, 1'b1);
    check("sr_hit_busy", busy, 1'b0);
    check("sr_hit_we", write_enb, 3'b000);
    check("sr_hit_lfd", lfd_state, 1'b0);
    cyc(1'b1, 8'h05, 3'b010, 3'b101);
    check("sr_drop1_busy", busy, 1'b0);
    check("sr_drop1_we", write_enb, 3'b000);
    cyc(1'b1, 8'h06, 3'b010);
    check("sr_drop2_busy", busy, 1'b0);
    check("sr_drop2_we", write_enb, 3'b000);
    check("sr_drop2_err", err, 1'b0);
    cyc(1'b0, 8'h00, 3'b010);
    check("sr_err_pulse", err, 1'b1);
    // Back in IDLE: a header to the full FIFO 1 is stalled.
    cyc(1'b1, 8'h01, 3'b010);
    check("sr_idle_busy", busy, 1'b1);
    check("sr_idle_we", write_enb, 3'b000);
    check("sr_err_clear", err, 1'b0);
    cyc(1'b0, 8'h00);

    // Reset mid-packet: header 0x0C (dest 0, L=3) + one payload byte.
    cyc(1'b1, 8'h0C);
    check("mr_hdr_we", write_enb, 3'b001);
    cyc(1'b1, 8'h99);
    @(negedge clock);
    resetn = 1'b0; pkt_valid = 1'b0; data_in = 8'h00;
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("mr_err", err, 1'b0);
    check("mr_soft_reset", soft_reset, 3'b000);
    check("mr_we", write_enb, 3'b000);
    check("mr_busy", busy, 1'b0);
    check("mr_lfd", lfd_state, 1'b0);
    // The next source byte is parsed as a fresh header (dest 1, L=0).
    cyc(1'b1, 8'h01);
    check("mr_new_hdr_we", write_enb, 3'b010);
    check("mr_new_hdr_lfd", lfd_state, 1'b1);
    cyc(1'b1, 8'h01);
    check("mr_new_par_we", write_enb, 3'b010);
    check("mr_new_par_lfd", lfd_state, 1'b0);
    cyc(1'b0, 8'h00);
    check("mr_new_err", err, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
